// File: rtl/systolic_fifo_sched.sv
// Feed-FIFO sequencer for the systolic array: loads k_len memory words into every
// lane in parallel, then drains the lanes with a one-cycle-per-lane diagonal skew.
module systolic_fifo_sched #(
  parameter int systolic_size = 2,
  parameter int ADDR_W        = 1,
  parameter int MEM_ADDR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_W:0]          k_len,
  input  logic [MEM_ADDR_W-1:0]    base_addr,
  output logic                     mem_rd_en,
  output logic [MEM_ADDR_W-1:0]    mem_addr,
  output logic [systolic_size-1:0] fifo_wr_en,
  output logic [systolic_size-1:0] fifo_rd_en,
  output logic [systolic_size-1:0] lane_valid,
  output logic                     busy,
  output logic                     done
);

  localparam int K_W = ADDR_W + 1;
  // Drain counter must reach k_len + systolic_size - 2 for the largest k_len.
  localparam int T_W = $clog2((1 << K_W) + systolic_size) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [MEM_ADDR_W-1:0]    base_q, base_d;
  logic [K_W-1:0]           j_q, j_d;
  logic [T_W-1:0]           t_q, t_d;
  logic                     wr_q, wr_d;
  logic [systolic_size-1:0] lv_q, lv_d;

  logic                     mem_rd_en_c;
  logic [MEM_ADDR_W-1:0]    mem_addr_c;
  logic [systolic_size-1:0] rd_en_c;
  logic [T_W-1:0]           t_end;

  assign t_end = T_W'(k_q) + T_W'(systolic_size) - T_W'(2);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    base_d      = base_q;
    j_d         = j_q;
    t_d         = t_q;
    mem_rd_en_c = 1'b0;
    mem_addr_c  = '0;
    rd_en_c     = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          if (k_len != '0) begin
            k_d     = k_len;
            base_d  = base_addr;
            j_d     = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        mem_rd_en_c = 1'b1;
        mem_addr_c  = base_q + MEM_ADDR_W'(j_q);
        if (j_q == k_q - K_W'(1)) begin
          j_d     = '0;
          state_d = ST_LOAD_WAIT;
        end else begin
          j_d = j_q + K_W'(1);
        end
      end
      ST_LOAD_WAIT: begin
        t_d     = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        for (int unsigned i = 0; i < systolic_size; i++) begin
          rd_en_c[i] = (t_q >= T_W'(i)) && (t_q < T_W'(i) + T_W'(k_q));
        end
        if (t_q == t_end) begin
          t_d     = '0;
          state_d = ST_DONE;
        end else begin
          t_d = t_q + T_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      j_d     = '0;
      t_d     = '0;
    end

    // Registered strobes are squashed on abort so nothing leaks into the IDLE cycle.
    wr_d = abort ? 1'b0 : mem_rd_en_c;
    lv_d = abort ? '0 : rd_en_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      base_q  <= '0;
      j_q     <= '0;
      t_q     <= '0;
      wr_q    <= 1'b0;
      lv_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      j_q     <= j_d;
      t_q     <= t_d;
      wr_q    <= wr_d;
      lv_q    <= lv_d;
    end
  end

  assign mem_rd_en  = mem_rd_en_c;
  assign mem_addr   = mem_addr_c;
  assign fifo_wr_en = {systolic_size{wr_q}};
  assign fifo_rd_en = rd_en_c;
  assign lane_valid = lv_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule
